// File: rtl/ring_target_agent.sv
// Ring-stop target agent: consumes ring requests for this CoreID, runs a
// local memory access and injects the response; other traffic takes 2 cycles.
//
// Ports:
//   QClk, RstQnnnL         clock, async active-low reset
//   CoreID                 this tile's ring ID
//   RingReqIn*Q500H        ring request channel in
//   RingRspIn*Q500H        ring response channel in
//   RingReqOut*Q502H       ring request channel out (hits become bubbles)
//   RingRspOut*Q502H       ring response channel out (carries injections)
//   MemReq*/MemWr*         local memory request (valid/ready)
//   MemRdDataValid/Data    local read data return
package ring_target_agent_pkg;
  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_RD     = 4'h1,
    OP_WR     = 4'h2,
    OP_RD_RSP = 4'h3,
    OP_WR_RSP = 4'h4,
    OP_ATOM   = 4'h5
  } t_opcode;

  typedef struct packed {
    logic [9:0]  req;
    t_opcode     op;
    logic [31:0] addr;
    logic [31:0] data;
  } ring_pkt_t;
endpackage

module ring_target_agent
  import ring_target_agent_pkg::*;
#(
  parameter int REQ_DEPTH   = 4,
  parameter int ADDR_ID_MSB = 31
) (
  input  logic        QClk,
  input  logic        RstQnnnL,
  input  logic [7:0]  CoreID,
  input  logic        RingReqInValidQ500H,
  input  logic [9:0]  RingReqInRequestorQ500H,
  input  t_opcode     RingReqInOpcodeQ500H,
  input  logic [31:0] RingReqInAddressQ500H,
  input  logic [31:0] RingReqInDataQ500H,
  input  logic        RingRspInValidQ500H,
  input  logic [9:0]  RingRspInRequestorQ500H,
  input  t_opcode     RingRspInOpcodeQ500H,
  input  logic [31:0] RingRspInAddressQ500H,
  input  logic [31:0] RingRspInDataQ500H,
  output logic        RingReqOutValidQ502H,
  output logic [9:0]  RingReqOutRequestorQ502H,
  output t_opcode     RingReqOutOpcodeQ502H,
  output logic [31:0] RingReqOutAddressQ502H,
  output logic [31:0] RingReqOutDataQ502H,
  output logic        RingRspOutValidQ502H,
  output logic [9:0]  RingRspOutRequestorQ502H,
  output t_opcode     RingRspOutOpcodeQ502H,
  output logic [31:0] RingRspOutAddressQ502H,
  output logic [31:0] RingRspOutDataQ502H,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic        MemWrEn,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWrData,
  input  logic        MemRdDataValid,
  input  logic [31:0] MemRdData
);

  localparam int AW = $clog2(REQ_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_MEM_REQ, S_MEM_RD, S_RSP_WAIT
  } state_t;

  state_t state_q, state_d;

  ring_pkt_t req_in, rsp_in;
  ring_pkt_t req501_q, req502_q;
  ring_pkt_t rsp501_q, rsp502_q;
  logic      req501_vld_q, req502_vld_q;
  logic      rsp501_vld_q, rsp502_vld_q;

  ring_pkt_t fifo_q [REQ_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  ring_pkt_t wrk_q, inj_pkt;
  logic [31:0] rdata_q;

  logic full, empty, hit, push, pop, cap, inject;

  assign req_in = '{req:  RingReqInRequestorQ500H,
                    op:   RingReqInOpcodeQ500H,
                    addr: RingReqInAddressQ500H,
                    data: RingReqInDataQ500H};
  assign rsp_in = '{req:  RingRspInRequestorQ500H,
                    op:   RingRspInOpcodeQ500H,
                    addr: RingRspInAddressQ500H,
                    data: RingRspInDataQ500H};

  // Depth is a power of two, so the count MSB alone means full.
  assign full  = cnt_q[AW];
  assign empty = cnt_q == '0;

  assign hit = RingReqInValidQ500H
             && RingReqInAddressQ500H[ADDR_ID_MSB -: 8] == CoreID
             && (RingReqInOpcodeQ500H == OP_RD
                 || RingReqInOpcodeQ500H == OP_WR)
             && !full;
  assign push = hit;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cap     = 1'b0;
    inject  = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_MEM_REQ;
        end
      S_MEM_REQ:
        if (MemReqReady)
          state_d = (wrk_q.op == OP_RD) ? S_MEM_RD : S_RSP_WAIT;
      S_MEM_RD:
        if (MemRdDataValid) begin
          cap     = 1'b1;
          state_d = S_RSP_WAIT;
        end
      S_RSP_WAIT:
        if (!rsp501_vld_q) begin
          inject  = 1'b1;
          state_d = S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inj_pkt      = wrk_q;
    inj_pkt.op   = (wrk_q.op == OP_RD) ? OP_RD_RSP : OP_WR_RSP;
    inj_pkt.data = (wrk_q.op == OP_RD) ? rdata_q : wrk_q.data;
  end

  always_ff @(posedge QClk) begin
    if (push) fifo_q[wr_ptr_q] <= req_in;
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wrk_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        wrk_q    <= fifo_q[rd_ptr_q];
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (cap) rdata_q <= MemRdData;
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      req501_vld_q <= 1'b0;
      req501_q     <= '0;
      req502_vld_q <= 1'b0;
      req502_q     <= '0;
      rsp501_vld_q <= 1'b0;
      rsp501_q     <= '0;
      rsp502_vld_q <= 1'b0;
      rsp502_q     <= '0;
    end else begin
      // A consumed request leaves an all-zero bubble behind.
      req501_vld_q <= RingReqInValidQ500H && !hit;
      req501_q     <= hit ? '0 : req_in;
      req502_vld_q <= req501_vld_q;
      req502_q     <= req501_q;
      rsp501_vld_q <= RingRspInValidQ500H;
      rsp501_q     <= rsp_in;
      rsp502_vld_q <= rsp501_vld_q || inject;
      rsp502_q     <= inject ? inj_pkt : rsp501_q;
    end
  end

  assign RingReqOutValidQ502H     = req502_vld_q;
  assign RingReqOutRequestorQ502H = req502_q.req;
  assign RingReqOutOpcodeQ502H    = req502_q.op;
  assign RingReqOutAddressQ502H   = req502_q.addr;
  assign RingReqOutDataQ502H      = req502_q.data;
  assign RingRspOutValidQ502H     = rsp502_vld_q;
  assign RingRspOutRequestorQ502H = rsp502_q.req;
  assign RingRspOutOpcodeQ502H    = rsp502_q.op;
  assign RingRspOutAddressQ502H   = rsp502_q.addr;
  assign RingRspOutDataQ502H      = rsp502_q.data;

  assign MemReqValid = state_q == S_MEM_REQ;
  assign MemWrEn     = MemReqValid && wrk_q.op == OP_WR;
  assign MemAddress  = MemReqValid ? wrk_q.addr : '0;
  assign MemWrData   = MemWrEn ? wrk_q.data : '0;

endmodule

// File: tb/tb_ring_target_agent.sv
// Directed bench for ring_target_agent: pass-through, hits, backpressure,
// FIFO full, response injection deferral and async reset.
module tb_ring_target_agent;
  import ring_target_agent_pkg::*;

  logic QClk = 1'b0;
  always #5 QClk = ~QClk;

  logic        RstQnnnL;
  logic [7:0]  CoreID;
  logic        rq_v, rs_v;
  logic [9:0]  rq_r, rs_r;
  t_opcode     rq_o, rs_o;
  logic [31:0] rq_a, rq_d, rs_a, rs_d;
  logic        qo_v, so_v;
  logic [9:0]  qo_r, so_r;
  t_opcode     qo_o, so_o;
  logic [31:0] qo_a, qo_d, so_a, so_d;
  logic        MemReqValid, MemReqReady, MemWrEn;
  logic [31:0] MemAddress, MemWrData;
  logic        MemRdDataValid;
  logic [31:0] MemRdData;

  ring_target_agent #(.REQ_DEPTH(4), .ADDR_ID_MSB(31)) dut (
    .QClk(QClk), .RstQnnnL(RstQnnnL), .CoreID(CoreID),
    .RingReqInValidQ500H(rq_v), .RingReqInRequestorQ500H(rq_r),
    .RingReqInOpcodeQ500H(rq_o), .RingReqInAddressQ500H(rq_a),
    .RingReqInDataQ500H(rq_d),
    .RingRspInValidQ500H(rs_v), .RingRspInRequestorQ500H(rs_r),
    .RingRspInOpcodeQ500H(rs_o), .RingRspInAddressQ500H(rs_a),
    .RingRspInDataQ500H(rs_d),
    .RingReqOutValidQ502H(qo_v), .RingReqOutRequestorQ502H(qo_r),
    .RingReqOutOpcodeQ502H(qo_o), .RingReqOutAddressQ502H(qo_a),
    .RingReqOutDataQ502H(qo_d),
    .RingRspOutValidQ502H(so_v), .RingRspOutRequestorQ502H(so_r),
    .RingRspOutOpcodeQ502H(so_o), .RingRspOutAddressQ502H(so_a),
    .RingRspOutDataQ502H(so_d),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
    .MemWrEn(MemWrEn), .MemAddress(MemAddress), .MemWrData(MemWrData),
    .MemRdDataValid(MemRdDataValid), .MemRdData(MemRdData)
  );

  logic [78:0] req_out, rsp_out;
  logic [65:0] mem_out;
  assign req_out = {qo_v, qo_r, qo_o, qo_a, qo_d};
  assign rsp_out = {so_v, so_r, so_o, so_a, so_d};
  assign mem_out = {MemReqValid, MemWrEn, MemAddress, MemWrData};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [78:0] got,
                     input logic [78:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [78:0] pk(input logic v, input logic [9:0] r,
                                     input t_opcode o,
                                     input logic [31:0] a,
                                     input logic [31:0] d);
    return {v, r, o, a, d};
  endfunction

  function automatic logic [78:0] trf(input int k);
    return pk(1'b1, 10'(10'h200 + k), OP_RD_RSP,
              32'(32'h0500_0000 + k), 32'(32'h1111_0000 + k));
  endfunction

  task automatic step();
    @(posedge QClk);
    #1;
  endtask

  task automatic drv_req(input logic [9:0] r, input t_opcode o,
                         input logic [31:0] a, input logic [31:0] d);
    rq_v = 1'b1; rq_r = r; rq_o = o; rq_a = a; rq_d = d;
  endtask

  task automatic clr_req();
    rq_v = 1'b0; rq_r = '0; rq_o = OP_NOP; rq_a = '0; rq_d = '0;
  endtask

  task automatic drv_rsp(input int k);
    rs_v = 1'b1;
    rs_r = 10'(10'h200 + k);
    rs_o = OP_RD_RSP;
    rs_a = 32'(32'h0500_0000 + k);
    rs_d = 32'(32'h1111_0000 + k);
  endtask

  task automatic clr_rsp();
    rs_v = 1'b0; rs_r = '0; rs_o = OP_NOP; rs_a = '0; rs_d = '0;
  endtask

  task automatic pass_thru(input string tag, input logic [9:0] r,
                           input t_opcode o, input logic [31:0] a,
                           input logic [31:0] d);
    drv_req(r, o, a, d);
    step();
    clr_req();
    chk({tag, "_q501"}, req_out, '0);
    step();
    chk(tag, req_out, pk(1'b1, r, o, a, d));
    chk({tag, "_nomem"}, 79'(MemReqValid), 79'(0));
    step();
    chk({tag, "_gone"}, 79'(qo_v), 79'(0));
  endtask

  task automatic read_hit(input string tag, input logic [9:0] r,
                          input logic [31:0] a, input logic [31:0] rd);
    MemReqReady = 1'b1;
    drv_req(r, OP_RD, a, 32'h0);
    step();
    clr_req();
    step();
    chk({tag, "_bubble"}, req_out, '0);
    chk({tag, "_memreq"}, 79'(mem_out), 79'({1'b1, 1'b0, a, 32'h0}));
    step();
    MemRdDataValid = 1'b1;
    MemRdData      = rd;
    step();
    MemRdDataValid = 1'b0;
    MemRdData      = '0;
    chk({tag, "_early"}, 79'(so_v), 79'(0));
    step();
    chk({tag, "_rsp"}, rsp_out, pk(1'b1, r, OP_RD_RSP, a, rd));
    step();
    chk({tag, "_rsp_once"}, 79'(so_v), 79'(0));
    MemReqReady = 1'b0;
  endtask

  initial begin
    int got_n;
    RstQnnnL = 1'b0;
    CoreID = 8'h03;
    clr_req();
    clr_rsp();
    MemReqReady = 1'b0;
    MemRdDataValid = 1'b0;
    MemRdData = '0;
    step();
    step();
    chk("rst_req", req_out, '0);
    chk("rst_rsp", rsp_out, '0);
    chk("rst_mem", 79'(mem_out), '0);
    RstQnnnL = 1'b1;
    step();

    pass_thru("miss", 10'h055, OP_RD, 32'h0100_0010, 32'hDEAD_BEEF);
    pass_thru("atom", 10'h044, OP_ATOM, 32'h0300_0000, 32'h0000_0077);

    read_hit("rdhit", 10'h012, 32'h0300_0040, 32'h1234_5678);

    drv_req(10'h021, OP_WR, 32'h0300_0008, 32'hA5A5_A5A5);
    step();
    clr_req();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("wr_hold", 79'(mem_out),
          79'({1'b1, 1'b1, 32'h0300_0008, 32'hA5A5_A5A5}));
      if (i == 3) MemReqReady = 1'b1;
      step();
    end
    MemReqReady = 1'b0;
    step();
    chk("wr_rsp", rsp_out,
        pk(1'b1, 10'h021, OP_WR_RSP, 32'h0300_0008, 32'hA5A5_A5A5));
    step();
    step();

    for (int i = 0; i < 6; i++) begin
      drv_req(10'(10'h100 + i), OP_WR, 32'(32'h0300_0100 + 4 * i),
              32'(32'hC0DE_0000 + i));
      step();
      if (i >= 1) chk("full_bubble", 79'(qo_v), 79'(0));
    end
    clr_req();
    step();
    chk("full_pass", req_out,
        pk(1'b1, 10'h105, OP_WR, 32'h0300_0114, 32'hC0DE_0005));
    MemReqReady = 1'b1;
    got_n = 0;
    for (int c = 0; c < 60 && got_n < 5; c++) begin
      step();
      if (so_v) begin
        chk("full_rsp", rsp_out,
            pk(1'b1, 10'(10'h100 + got_n), OP_WR_RSP,
               32'(32'h0300_0100 + 4 * got_n),
               32'(32'hC0DE_0000 + got_n)));
        got_n++;
      end
    end
    chk("full_rsp_cnt", 79'(got_n), 79'(5));
    step();
    step();

    drv_req(10'h033, OP_WR, 32'h0300_0200, 32'h5A5A_0001);
    step();
    clr_req();
    step();
    for (int k = 0; k < 4; k++) begin
      drv_rsp(k);
      step();
      if (k >= 1) chk("defer_fwd", rsp_out, trf(k - 1));
    end
    clr_rsp();
    step();
    chk("defer_fwd", rsp_out, trf(3));
    step();
    chk("defer_inj", rsp_out,
        pk(1'b1, 10'h033, OP_WR_RSP, 32'h0300_0200, 32'h5A5A_0001));
    step();
    chk("defer_once", 79'(so_v), 79'(0));
    step();

    drv_req(10'h066, OP_RD, 32'h0300_0300, 32'h0);
    step();
    drv_req(10'h067, OP_RD, 32'h0300_0304, 32'h0);
    drv_rsp(7);
    step();
    clr_req();
    clr_rsp();
    step();
    chk("rst_pre_rsp", rsp_out, trf(7));
    #1;
    RstQnnnL = 1'b0;
    #1;
    chk("rst_async_rsp", rsp_out, '0);
    chk("rst_async_req", req_out, '0);
    chk("rst_async_mem", 79'(mem_out), '0);
    MemReqReady = 1'b0;
    step();
    step();
    RstQnnnL = 1'b1;
    MemReqReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_fifo_empty", 79'(MemReqValid), 79'(0));
    end
    read_hit("post_rst", 10'h0AB, 32'h0300_0ABC, 32'hFEED_F00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
